// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter.
// Each requester has a one-deep registered response slot.
module alu_arbiter #(
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_op_a,
   input  logic [31:0] req0_op_b,
   input  logic [1:0]  req0_alu_sel,
   input  logic        req0_ariph_op,
   input  logic [1:0]  req0_shift_op,
   input  logic [1:0]  req0_log_op,
   input  logic [4:0]  req0_shamt,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_overflow,
   output logic        rsp0_zero,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_op_a,
   input  logic [31:0] req1_op_b,
   input  logic [1:0]  req1_alu_sel,
   input  logic        req1_ariph_op,
   input  logic [1:0]  req1_shift_op,
   input  logic [1:0]  req1_log_op,
   input  logic [4:0]  req1_shamt,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_overflow,
   output logic        rsp1_zero,

   output logic [15:0] stat_cnt0,
   output logic [15:0] stat_cnt1,
   output logic        last_grant
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          elig0, elig1, grant0, grant1;
   logic          ptr_d, ptr_q, last_d, last_q;
   logic          rsp0_valid_d, rsp0_valid_q, rsp1_valid_d, rsp1_valid_q;
   logic [DW-1:0] rsp0_res_d, rsp0_res_q, rsp1_res_d, rsp1_res_q;
   logic          rsp0_ovf_d, rsp0_ovf_q, rsp1_ovf_d, rsp1_ovf_q;
   logic          rsp0_zero_d, rsp0_zero_q, rsp1_zero_d, rsp1_zero_q;
   logic [CW-1:0] cnt0_d, cnt0_q, cnt1_d, cnt1_q;

   logic [DW-1:0] alu_a, alu_b, add_b, sum;
   logic [1:0]    alu_sel, alu_shop, alu_logop;
   logic          alu_ariph;
   logic [4:0]    alu_shamt, shamt_neg;
   logic [DW-1:0] alu_res;
   logic          alu_ovf, alu_zero;

   // A full slot only blocks its requester when it is not draining this cycle
   assign elig0  = req0_valid && (!rsp0_valid_q || rsp0_ready);
   assign elig1  = req1_valid && (!rsp1_valid_q || rsp1_ready);
   assign grant0 = !rst && elig0 && (!elig1 || !ptr_q);
   assign grant1 = !rst && elig1 && (!elig0 || ptr_q);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Operand mux: requester 0 drives the ALU whenever requester 1 is not granted
   always_comb begin
      alu_a     = req0_op_a;
      alu_b     = req0_op_b;
      alu_sel   = req0_alu_sel;
      alu_ariph = req0_ariph_op;
      alu_shop  = req0_shift_op;
      alu_logop = req0_log_op;
      alu_shamt = req0_shamt;
      if (grant1) begin
         alu_a     = req1_op_a;
         alu_b     = req1_op_b;
         alu_sel   = req1_alu_sel;
         alu_ariph = req1_ariph_op;
         alu_shop  = req1_shift_op;
         alu_logop = req1_log_op;
         alu_shamt = req1_shamt;
      end
   end

   // Shared ALU
   always_comb begin
      add_b     = alu_ariph ? ~alu_b : alu_b;
      sum       = alu_a + add_b + DW'(alu_ariph);
      shamt_neg = 5'(~alu_shamt + 5'd1);
      alu_res   = '0;
      alu_ovf   = 1'b0;
      unique case (alu_sel)
         2'b00: begin
            unique case (alu_shop)
               2'b00: alu_res = alu_b << alu_shamt;
               2'b01: alu_res = alu_b >> alu_shamt;
               2'b10: alu_res = DW'($signed(alu_b) >>> alu_shamt);
               2'b11: alu_res = (alu_b >> alu_shamt) | (alu_b << shamt_neg);
            endcase
         end
         2'b01: alu_res = DW'($signed(alu_a) < $signed(alu_b));
         2'b10: begin
            alu_res = sum;
            alu_ovf = (alu_a[DW-1] == add_b[DW-1]) && (sum[DW-1] != alu_a[DW-1]);
         end
         2'b11: begin
            unique case (alu_logop)
               2'b00: alu_res = alu_a & alu_b;
               2'b01: alu_res = alu_a | alu_b;
               2'b10: alu_res = ~(alu_a | alu_b);
               2'b11: alu_res = alu_a ^ alu_b;
            endcase
         end
      endcase
      alu_zero = (alu_res == '0);
   end

   // Next state: a grant refills the slot, otherwise a handshake empties it
   always_comb begin
      ptr_d        = ptr_q;
      last_d       = last_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp0_res_d   = rsp0_res_q;
      rsp0_ovf_d   = rsp0_ovf_q;
      rsp0_zero_d  = rsp0_zero_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_res_d   = rsp1_res_q;
      rsp1_ovf_d   = rsp1_ovf_q;
      rsp1_zero_d  = rsp1_zero_q;

      if (grant0) begin
         rsp0_valid_d = 1'b1;
         rsp0_res_d   = alu_res;
         rsp0_ovf_d   = alu_ovf;
         rsp0_zero_d  = alu_zero;
         cnt0_d       = cnt0_q + CW'(1);
         ptr_d        = 1'b1;
         last_d       = 1'b0;
      end else if (rsp0_valid_q && rsp0_ready) begin
         rsp0_valid_d = 1'b0;
      end

      if (grant1) begin
         rsp1_valid_d = 1'b1;
         rsp1_res_d   = alu_res;
         rsp1_ovf_d   = alu_ovf;
         rsp1_zero_d  = alu_zero;
         cnt1_d       = cnt1_q + CW'(1);
         ptr_d        = 1'b0;
         last_d       = 1'b1;
      end else if (rsp1_valid_q && rsp1_ready) begin
         rsp1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q        <= PRIO_INIT;
         last_q       <= PRIO_INIT;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
         rsp0_valid_q <= 1'b0;
         rsp0_res_q   <= '0;
         rsp0_ovf_q   <= 1'b0;
         rsp0_zero_q  <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_res_q   <= '0;
         rsp1_ovf_q   <= 1'b0;
         rsp1_zero_q  <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         last_q       <= last_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_res_q   <= rsp0_res_d;
         rsp0_ovf_q   <= rsp0_ovf_d;
         rsp0_zero_q  <= rsp0_zero_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_res_q   <= rsp1_res_d;
         rsp1_ovf_q   <= rsp1_ovf_d;
         rsp1_zero_q  <= rsp1_zero_d;
      end
   end

   assign rsp0_valid    = rsp0_valid_q;
   assign rsp0_result   = rsp0_res_q;
   assign rsp0_overflow = rsp0_ovf_q;
   assign rsp0_zero     = rsp0_zero_q;
   assign rsp1_valid    = rsp1_valid_q;
   assign rsp1_result   = rsp1_res_q;
   assign rsp1_overflow = rsp1_ovf_q;
   assign rsp1_zero     = rsp1_zero_q;
   assign stat_cnt0     = cnt0_q;
   assign stat_cnt1     = cnt1_q;
   assign last_grant    = last_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors, corner sequences and random traffic
// checked against a transaction-level model of the arbiter and ALU.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
   logic [1:0]  req0_alu_sel, req0_shift_op, req0_log_op;
   logic [1:0]  req1_alu_sel, req1_shift_op, req1_log_op;
   logic        req0_ariph_op, req1_ariph_op;
   logic [4:0]  req0_shamt, req1_shamt;
   logic        rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_zero;
   logic        rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_zero;
   logic [31:0] rsp0_result, rsp1_result;
   logic [15:0] stat_cnt0, stat_cnt1;
   logic        last_grant;

   always #5 clk = ~clk;

   alu_arbiter #(.PRIO_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
      .req0_alu_sel(req0_alu_sel), .req0_ariph_op(req0_ariph_op),
      .req0_shift_op(req0_shift_op), .req0_log_op(req0_log_op),
      .req0_shamt(req0_shamt),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
      .req1_alu_sel(req1_alu_sel), .req1_ariph_op(req1_ariph_op),
      .req1_shift_op(req1_shift_op), .req1_log_op(req1_log_op),
      .req1_shamt(req1_shamt),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero),
      .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .last_grant(last_grant)
   );

   int errors = 0;
   int checks = 0;

   // Model state
   int          m_ptr, m_last;
   logic        m_v[2];
   logic [31:0] m_res[2];
   logic        m_ovf[2], m_zero[2];
   logic [15:0] m_cnt[2];
   logic        g0, g1;
   logic        act_r0, act_r1;

   typedef struct {
      logic [1:0]  sel;
      logic        ariph;
      logic [1:0]  shop;
      logic [1:0]  logop;
      logic [4:0]  shamt;
      logic [31:0] a, b, res;
      logic        ovf, zero;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference ALU from the arithmetic definitions; returns {overflow, result}
   function automatic logic [32:0] ref_alu(input logic [1:0] sel, input logic ariph,
                                           input logic [1:0] shop, input logic [1:0] logop,
                                           input logic [4:0] shamt,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r;
      logic [31:0] res;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = 32'd0;
      ovf = 1'b0;
      case (sel)
         2'b10: begin
            r   = ariph ? sa - sb : sa + sb;
            ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            res = r[31:0];
         end
         2'b01: res = (sa < sb) ? 32'd1 : 32'd0;
         2'b00: begin
            case (shop)
               2'b00: begin r = longint'(b) * (longint'(1) << shamt); res = r[31:0]; end
               2'b01: begin r = longint'(b) / (longint'(1) << shamt); res = r[31:0]; end
               2'b10: begin r = sb >>> shamt; res = r[31:0]; end
               default: begin
                  res = b;
                  for (int k = 0; k < int'(shamt); k++) res = {res[0], res[31:1]};
               end
            endcase
         end
         default: begin
            case (logop)
               2'b00: res = a & b;
               2'b01: res = a | b;
               2'b10: res = ~(a | b);
               default: res = a ^ b;
            endcase
         end
      endcase
      return {ovf, res};
   endfunction

   task automatic set_req(input int idx, input logic v, input logic [1:0] sel, input logic ariph,
                          input logic [1:0] shop, input logic [1:0] logop, input logic [4:0] shamt,
                          input logic [31:0] a, input logic [31:0] b);
      if (idx == 0) begin
         req0_valid = v; req0_alu_sel = sel; req0_ariph_op = ariph; req0_shift_op = shop;
         req0_log_op = logop; req0_shamt = shamt; req0_op_a = a; req0_op_b = b;
      end else begin
         req1_valid = v; req1_alu_sel = sel; req1_ariph_op = ariph; req1_shift_op = shop;
         req1_log_op = logop; req1_shamt = shamt; req1_op_a = a; req1_op_b = b;
      end
   endtask

   // One clock: check ready against the model, clock, advance model, check outputs
   task automatic step();
      logic e0, e1;
      logic [32:0] r0, r1;
      #2;
      e0 = req0_valid && (!m_v[0] || rsp0_ready);
      e1 = req1_valid && (!m_v[1] || rsp1_ready);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst) begin
         if (e0 && e1) begin
            if (m_ptr == 0) g0 = 1'b1; else g1 = 1'b1;
         end else begin
            g0 = e0;
            g1 = e1;
         end
      end
      act_r0 = req0_ready;
      act_r1 = req1_ready;
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      r0 = ref_alu(req0_alu_sel, req0_ariph_op, req0_shift_op, req0_log_op, req0_shamt, req0_op_a, req0_op_b);
      r1 = ref_alu(req1_alu_sel, req1_ariph_op, req1_shift_op, req1_log_op, req1_shamt, req1_op_a, req1_op_b);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_res[i] = '0; m_ovf[i] = 1'b0; m_zero[i] = 1'b0; m_cnt[i] = '0;
         end
         m_ptr  = 0;
         m_last = 0;
      end else begin
         if (g0) begin
            m_v[0] = 1'b1; m_res[0] = r0[31:0]; m_ovf[0] = r0[32]; m_zero[0] = (r0[31:0] == 0);
            m_cnt[0] = m_cnt[0] + 16'd1; m_ptr = 1; m_last = 0;
         end else if (m_v[0] && rsp0_ready) m_v[0] = 1'b0;
         if (g1) begin
            m_v[1] = 1'b1; m_res[1] = r1[31:0]; m_ovf[1] = r1[32]; m_zero[1] = (r1[31:0] == 0);
            m_cnt[1] = m_cnt[1] + 16'd1; m_ptr = 0; m_last = 1;
         end else if (m_v[1] && rsp1_ready) m_v[1] = 1'b0;
      end
      #1;
      chk("rsp0_valid", 32'(rsp0_valid), 32'(m_v[0]));
      chk("rsp0_result", rsp0_result, m_res[0]);
      chk("rsp0_overflow", 32'(rsp0_overflow), 32'(m_ovf[0]));
      chk("rsp0_zero", 32'(rsp0_zero), 32'(m_zero[0]));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(m_v[1]));
      chk("rsp1_result", rsp1_result, m_res[1]);
      chk("rsp1_overflow", 32'(rsp1_overflow), 32'(m_ovf[1]));
      chk("rsp1_zero", 32'(rsp1_zero), 32'(m_zero[1]));
      chk("stat_cnt0", 32'(stat_cnt0), 32'(m_cnt[0]));
      chk("stat_cnt1", 32'(stat_cnt1), 32'(m_cnt[1]));
      chk("last_grant", 32'(last_grant), 32'(m_last));
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'(1);
         default: return $urandom();
      endcase
   endfunction

   vec_t vecs[14];

   initial begin
      logic [31:0] hold;
      int exp_order[4];

      vecs[0]  = '{2'b10, 1'b0, 2'b00, 2'b00, 5'd0,  32'd7,         32'd9,         32'd16,        1'b0, 1'b0};
      vecs[1]  = '{2'b10, 1'b0, 2'b00, 2'b00, 5'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1'b0};
      vecs[2]  = '{2'b01, 1'b1, 2'b00, 2'b00, 5'd0,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
      vecs[3]  = '{2'b00, 1'b0, 2'b10, 2'b00, 5'd4,  32'd0,         32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 1'b0, 2'b11, 2'b00, 5'd1,  32'd0,         32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
      vecs[5]  = '{2'b10, 1'b1, 2'b00, 2'b00, 5'd0,  32'd5,         32'd5,         32'd0,         1'b0, 1'b1};
      vecs[6]  = '{2'b11, 1'b0, 2'b00, 2'b01, 5'd0,  32'h0F,        32'hF0,        32'hFF,        1'b0, 1'b0};
      vecs[7]  = '{2'b11, 1'b0, 2'b00, 2'b10, 5'd0,  32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[8]  = '{2'b10, 1'b1, 2'b00, 2'b00, 5'd0,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0};
      vecs[9]  = '{2'b00, 1'b0, 2'b00, 2'b00, 5'd31, 32'd0,         32'd1,         32'h8000_0000, 1'b0, 1'b0};
      vecs[10] = '{2'b00, 1'b0, 2'b01, 2'b00, 5'd31, 32'd0,         32'h8000_0000, 32'd1,         1'b0, 1'b0};
      vecs[11] = '{2'b11, 1'b0, 2'b00, 2'b11, 5'd0,  32'hFF,        32'h0F,        32'hF0,        1'b0, 1'b0};
      vecs[12] = '{2'b11, 1'b0, 2'b00, 2'b00, 5'd0,  32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0};
      vecs[13] = '{2'b00, 1'b0, 2'b11, 2'b00, 5'd0,  32'd0,         32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
      exp_order = '{0, 1, 0, 1};

      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_res[i] = '0; m_ovf[i] = 1'b0; m_zero[i] = 1'b0; m_cnt[i] = '0;
      end
      m_ptr = 0; m_last = 0;

      // Reset held two cycles with both requesters valid
      rst = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      set_req(0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 5'd0, 32'd1, 32'd2);
      set_req(1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 5'd0, 32'd3, 32'd4);
      @(posedge clk);
      #1;
      step();
      chk("reset_ready0", 32'(act_r0), 32'd0);
      step();
      chk("reset_ready1", 32'(act_r1), 32'd0);
      rst = 1'b0;
      set_req(0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 5'd0, 32'd0, 32'd0);
      step();
      chk("post_reset_last_grant", 32'(last_grant), 32'd0);

      // Directed ALU vectors on requester 0 alone
      foreach (vecs[i]) begin
         set_req(0, 1'b1, vecs[i].sel, vecs[i].ariph, vecs[i].shop, vecs[i].logop, vecs[i].shamt,
                 vecs[i].a, vecs[i].b);
         step();
         chk($sformatf("vec%0d_result", i), rsp0_result, vecs[i].res);
         chk($sformatf("vec%0d_overflow", i), 32'(rsp0_overflow), 32'(vecs[i].ovf));
         chk($sformatf("vec%0d_zero", i), 32'(rsp0_zero), 32'(vecs[i].zero));
         if (i == 0) chk("first_add_cnt0", 32'(stat_cnt0), 32'd1);
      end
      chk("vec_cnt0", 32'(stat_cnt0), 32'd14);
      req0_valid = 1'b0;

      // Alternation from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_req(0, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 5'd0, 32'd5, 32'd5);
      set_req(1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 5'd0, 32'h0F, 32'hF0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("alt_grant%0d", i), act_r1 ? 32'd1 : (act_r0 ? 32'd0 : 32'hFFFF_FFFF),
             32'(exp_order[i]));
      end
      chk("alt_rsp0_result", rsp0_result, 32'd0);
      chk("alt_rsp0_zero", 32'(rsp0_zero), 32'd1);
      chk("alt_rsp1_result", rsp1_result, 32'hFF);

      // Backpressure on requester 0
      rsp0_ready = 1'b0;
      step();
      chk("bp_first_grant0", 32'(act_r0), 32'd1);
      hold = rsp0_result;
      set_req(0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 5'd0, 32'd7, 32'd9);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_req0_blocked", 32'(act_r0), 32'd0);
         chk("bp_req1_granted", 32'(act_r1), 32'd1);
         chk("bp_rsp0_stable", rsp0_result, hold);
      end
      rsp0_ready = 1'b1;
      step();
      chk("bp_release_grant0", 32'(act_r0), 32'd1);
      chk("bp_release_result", rsp0_result, 32'd16);

      // Reset while requester 1 holds an unconsumed response
      req0_valid = 1'b0;
      rsp1_ready = 1'b0;
      step();
      req1_valid = 1'b0;
      step();
      chk("mid_rsp1_held", 32'(rsp1_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("mid_cnt1", 32'(stat_cnt1), 32'd0);
      chk("mid_last_grant", 32'(last_grant), 32'd0);
      rsp1_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      chk("mid_ptr_init", 32'(act_r0), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         rsp0_ready = ($urandom_range(0, 2) != 0);
         rsp1_ready = ($urandom_range(0, 2) != 0);
         set_req(0, $urandom_range(0, 3) != 0, 2'($urandom()), 1'($urandom()), 2'($urandom()),
                 2'($urandom()), 5'($urandom()), rnd_operand(), rnd_operand());
         set_req(1, $urandom_range(0, 3) != 0, 2'($urandom()), 1'($urandom()), 2'($urandom()),
                 2'($urandom()), 5'($urandom()), rnd_operand(), rnd_operand());
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` datapath instance between two independent requesters, e.g. the execute stage and the address-generation unit. It arbitrates round-robin, drives the shared `alu` with the winning request's operation, and captures each result into a per-requester response register. Both sides use a valid/ready handshake. Peak throughput is one ALU operation per cycle; latency is one cycle.

## Interface
- `PRIO_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0 is granted this cycle; the transfer occurs when `req0_valid` and `req0_ready` are both high.
- `req0_op_a`, `req0_op_b` in 32 each: operands.
- `req0_alu_sel` in 2: 00 shift, 01 set-on-less-than, 10 add/sub, 11 logic.
- `req0_ariph_op` in 1: 0 add, 1 subtract (also used for SLT).
- `req0_shift_op` in 2: 00 sll, 01 srl, 10 sra, 11 rotate right.
- `req0_log_op` in 2: 00 and, 01 or, 10 nor, 11 xor.
- `req0_shamt` in 5: shift amount.
- `rsp0_valid` out 1: a response is held for requester 0.
- `rsp0_ready` in 1: requester 0 consumes the response.
- `rsp0_result` out 32, `rsp0_overflow` out 1, `rsp0_zero` out 1: registered `alu` outputs.
- `req1_*` / `rsp1_*`: identical set for requester 1.
- `stat_cnt0`, `stat_cnt1` out 16 each: granted-operation counters, wrapping.
- `last_grant` out 1: index of the most recent grant.

## Operation
- **Eligibility:**
  - eligible_i = `req_i_valid` && (!`rsp_i_valid` || `rsp_i_ready`).
  - A requester whose response slot is full and not draining is never granted.
- **Arbitration (combinational):**
  - Exactly one of eligible_0 / eligible_1 → that requester is granted.
  - Both eligible → the requester named by the priority pointer is granted.
  - Neither eligible → no grant.
  - `req_i_ready` = grant_i.
- **Priority pointer:** on any grant, pointer ← index of the non-granted requester. The pointer is unchanged on idle cycles.
- **Datapath:**
  - All `alu` control and operand inputs are muxed from the granted requester.
  - With no grant, requester 0's fields drive the `alu`; the result is unobservable.
  - `alu` result, overflow and zero are taken as produced by the shared `alu`: 32-bit two's-complement, overflow = signed overflow of add/sub, zero = result == 0.
- **Response register i, per edge, priority order:**
  1. `rst` → valid 0, result 0, overflow 0, zero 0.
  2. grant_i → load result/overflow/zero, valid 1. This also covers drain-and-refill in the same cycle.
  3. `rsp_i_valid` && `rsp_i_ready` → valid 0; the data fields hold their value.
  4. Otherwise → hold.
- **Counters:** `stat_cnt_i` increments by 1 on each grant_i and wraps from 0xFFFF to 0. Reset value 0.
- **`last_grant`:** updated on each grant. Reset value `PRIO_INIT`.

## Timing
- Reset values:
  - every `rsp_i_valid` = 0, all response fields = 0;
  - `stat_cnt_i` = 0;
  - pointer = `PRIO_INIT`, `last_grant` = `PRIO_INIT`.
- `req_i_ready` is 0 while `rst` is high.
- Latency: an operation accepted at edge N has its response visible with `rsp_i_valid` = 1 after edge N.
- Combinational paths:
  - `req_i_ready` depends on `req0_valid`, `req1_valid`, `rsp_i_valid`, `rsp_i_ready` and the pointer;
  - requesters must not make `req_i_valid` depend on `req_i_ready`.
- Sustained throughput:
  - one requester alone with `rsp_ready` held at 1: one operation per cycle;
  - both requesters continuously valid: strict alternation, one grant per cycle in total.
- Backpressure: `rsp_i_valid` and its data hold stable until the requester accepts. During that time requester i receives no grant and the other requester may use every cycle.
- Reset mid-operation: held responses are discarded, with no partial state remaining. `stat_cnt` is cleared.
- Requester inputs are sampled only in the granted cycle and need not stay stable afterwards.

## Test plan
- Hold `rst` for 2 cycles with both `req_valid` = 1 → `req_ready` = 0 throughout; after release, `rsp_valid` = 0, `stat_cnt` = 0, `last_grant` = `PRIO_INIT`.
- Single-requester add: req0 with a = 7, b = 9, sel = 10, ariph = 0 for one cycle → next cycle `rsp0_valid` = 1, result = 16, overflow = 0, zero = 0, `stat_cnt0` = 1.
- Alternation with `PRIO_INIT` = 0: both requesters valid for 4 cycles with `rsp_ready` = 1; req0 does sub a = 5, b = 5; req1 does or a = 0x0F, b = 0xF0 → grants in order 0, 1, 0, 1; rsp0 result 0 with zero = 1; rsp1 result 0xFF.
- Backpressure: `rsp0_ready` = 0 after the first rsp0 while both requesters stay valid → `req0_ready` stays 0; rsp0 data stays stable; req1 is granted every cycle. Raising `rsp0_ready` → req0 is granted in that same cycle.
- Arithmetic corners:
  - add 0x7FFFFFFF + 1 → result 0x80000000, overflow = 1;
  - SLT with a = 0xFFFFFFFF, b = 1, ariph = 1 → result 1;
  - sra of b = 0x80000000 by 4 → 0xF8000000;
  - rotate-right of b = 0x00000001 by 1 → 0x80000000.
- Reset mid-operation: assert `rst` for 1 cycle while `rsp1_valid` = 1 and `rsp1_ready` = 0 → next cycle `rsp1_valid` = 0, `stat_cnt1` = 0, pointer = `PRIO_INIT`.
